// File: rtl/simpleadder_result_deser.sv
// Deserialises the serial adder's MSB-first result frames into words and queues them in a FWFT FIFO.
// Optional per-frame statistics counters are built when STATS_EN is defined.
module simpleadder_result_deser #(
  parameter int unsigned RES_W = 3,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LVL_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ser_en_i,
  input  logic             ser_d_i,
  output logic [RES_W-1:0] res_data_o,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [LVL_W-1:0] fifo_level_o,
  output logic             ovf_o,
  output logic             frame_err_o,
  input  logic             clr_i,
  output logic [7:0]       frame_cnt_o,
  output logic [7:0]       drop_cnt_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RES_W + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state_q, state_d;
  logic [RES_W-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   bitcnt_q, bitcnt_d;
  logic [RES_W-1:0]   shifted_c;
  logic [RES_W-1:0]   word_c;
  logic               push_c;
  logic               ferr_set_c;

  logic [RES_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q, rd_nxt_c;
  logic               full_c, pop_c, wr_en_c, drop_c;
  logic [LVL_W-1:0]   level_d;
  logic [RES_W-1:0]   head_d;

  // Frame capture state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
    end
  end

  // Frame capture next-state: a strobe always starts a fresh frame with its bit as MSB
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bitcnt_d   = bitcnt_q;
    push_c     = 1'b0;
    ferr_set_c = 1'b0;
    shifted_c  = RES_W'({shreg_q, ser_d_i});
    word_c     = shifted_c;
    case (state_q)
      IDLE: begin
        if (ser_en_i) begin
          shreg_d  = RES_W'(ser_d_i);
          bitcnt_d = CNT_W'(1);
          if (RES_W == 1) begin
            push_c = 1'b1;
            word_c = RES_W'(ser_d_i);
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (ser_en_i) begin
          ferr_set_c = 1'b1;
          shreg_d    = RES_W'(ser_d_i);
          bitcnt_d   = CNT_W'(1);
          if (RES_W == 1) begin
            push_c  = 1'b1;
            word_c  = RES_W'(ser_d_i);
            state_d = IDLE;
          end
        end else begin
          shreg_d  = shifted_c;
          bitcnt_d = bitcnt_q + CNT_W'(1);
          if (bitcnt_q + CNT_W'(1) == CNT_W'(RES_W)) begin
            push_c   = 1'b1;
            word_c   = shifted_c;
            bitcnt_d = '0;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO control; the head register lets res_data_o hold its value once the FIFO drains
  always_comb begin
    full_c   = (fifo_level_o == LVL_W'(DEPTH));
    pop_c    = res_valid_o & res_ready_i;
    wr_en_c  = push_c & (~full_c | pop_c);
    drop_c   = push_c & full_c & ~pop_c;
    rd_nxt_c = rd_ptr_q + PTR_W'(1);
    level_d  = fifo_level_o;
    head_d   = res_data_o;
    if (wr_en_c && !pop_c) begin
      level_d = fifo_level_o + LVL_W'(1);
    end else if (!wr_en_c && pop_c) begin
      level_d = fifo_level_o - LVL_W'(1);
    end
    if (pop_c) begin
      if (fifo_level_o == LVL_W'(1)) begin
        if (wr_en_c) head_d = word_c;
      end else begin
        head_d = mem[rd_nxt_c];
      end
    end else if (!res_valid_o && wr_en_c) begin
      head_d = word_c;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_c && !rst) mem[wr_ptr_q] <= word_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_level_o <= '0;
      res_valid_o  <= 1'b0;
      res_data_o   <= '0;
      ovf_o        <= 1'b0;
      frame_err_o  <= 1'b0;
    end else begin
      if (wr_en_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)   rd_ptr_q <= rd_nxt_c;
      fifo_level_o <= level_d;
      res_valid_o  <= (level_d != '0);
      res_data_o   <= head_d;
      // Set beats clear when both happen in the same cycle
      if (drop_c)          ovf_o <= 1'b1;
      else if (clr_i)      ovf_o <= 1'b0;
      if (ferr_set_c)      frame_err_o <= 1'b1;
      else if (clr_i)      frame_err_o <= 1'b0;
    end
  end

`ifdef STATS_EN
  // Saturating frame/drop statistics, untouched by clr_i
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_o <= '0;
      drop_cnt_o  <= '0;
    end else begin
      if (push_c && frame_cnt_o != 8'hFF) frame_cnt_o <= frame_cnt_o + 8'd1;
      if (drop_c && drop_cnt_o != 8'hFF)  drop_cnt_o  <= drop_cnt_o + 8'd1;
    end
  end
`else
  assign frame_cnt_o = 8'd0;
  assign drop_cnt_o  = 8'd0;
`endif

endmodule
